// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue. It keeps the fetch PC and issues in-order word reads to
// instruction memory. Returned words are buffered with their PCs in a first-word-fall-through
// FIFO, and {pc, instr} is handed to decode over a valid/ready handshake. A redirect flushes
// the buffer and squashes the reads that are still in flight.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   redirect_valid, redirect_pc       fetch redirect (pc bits [1:0] ignored)
//   imem_req_valid/ready/addr         read request channel
//   imem_resp_valid/data              in-order read response (never backpressured)
//   out_valid/ready, out_pc/instr     decode-side handshake
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] fifo_count_q, fifo_count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   pc_mem_q    [FIFO_DEPTH];
    logic [31:0]   instr_mem_q [FIFO_DEPTH];

    logic [SW-1:0] credit_used;
    logic          req_fire;
    logic          resp_ok;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_pc_aligned;

    // Buffered words plus in-flight reads may never exceed the FIFO depth, so every
    // non-dropped response is guaranteed a slot.
    assign credit_used    = SW'(fifo_count_q) + SW'(inflight_q);
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < SW'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing in flight is a protocol error; it is ignored.
    assign resp_ok             = imem_resp_valid && (inflight_q != '0);
    assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

    assign out_valid = !rst && (fifo_count_q != '0);
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign pop       = out_valid && out_ready;

    // Next-state logic; a redirect overrides every other event in its cycle.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        fifo_count_d = fifo_count_q;
        inflight_d   = inflight_q;
        drop_cnt_d   = drop_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        push         = 1'b0;

        if (redirect_valid) begin
            fetch_pc_d   = redirect_pc_aligned;
            resp_pc_d    = redirect_pc_aligned;
            // Everything still outstanding belongs to the old path; a response arriving
            // now is dropped immediately, so it does not need a drop credit.
            drop_cnt_d   = inflight_q - CW'(resp_ok);
            inflight_d   = inflight_q - CW'(resp_ok);
            fifo_count_d = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_ok) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(resp_ok);
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            fifo_count_q <= '0;
            inflight_q   <= '0;
            drop_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            fifo_count_q <= fifo_count_d;
            inflight_q   <= inflight_d;
            drop_cnt_q   <= drop_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only observed when the count says they are valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem_q[wr_ptr_q]    <= resp_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_resp_data;
        end
    end

    // Counter bounds and response protocol checks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_count_bound: assert (fifo_count_q <= CW'(FIFO_DEPTH));
            a_inflight_bound: assert (inflight_q <= CW'(FIFO_DEPTH));
            a_resp_expected: assert (!(imem_resp_valid && (inflight_q == '0)));
        end
    end

endmodule
